// File: rtl/craps_game_ctrl_if.sv
// Roll request in, dice/point/result display values out.
// master = button/display side, slave = the game controller.
interface craps_game_ctrl_if;
    logic       roll;
    logic [3:0] dice1;
    logic [3:0] dice2;
    logic [3:0] point;
    logic       point_active;
    logic       win;
    logic       lose;

    modport master (
        output roll,
        input  dice1, dice2, point, point_active, win, lose
    );

    modport slave (
        input  roll,
        output dice1, dice2, point, point_active, win, lose
    );
endinterface

// File: rtl/craps_game_ctrl.sv
// Craps game controller: free-running dice counters sampled on a roll edge,
// come-out / point rules, result held until the next roll starts a new game.
module craps_game_ctrl #(
    parameter logic [3:0] DIE1_INIT = 4'd1,
    parameter logic [3:0] DIE2_INIT = 4'd1
) (
    input logic              clk,
    input logic              rst,
    craps_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {COMEOUT, POINT, WIN, LOSE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [3:0] dice1_q, dice1_d, dice2_q, dice2_d, point_q, point_d;
    logic       pa_q, pa_d, win_q, win_d, lose_q, lose_d;
    logic       roll_q, roll_d;
    logic       roll_pulse;
    logic [3:0] sum;

    always_comb begin
        roll_d     = bus.roll;
        roll_pulse = bus.roll & ~roll_q;
        sum        = cnt1_q + cnt2_q;

        // die 2 advances only when die 1 wraps, so 36 clocks visit every pair
        cnt1_d = (cnt1_q == 4'd6) ? 4'd1 : cnt1_q + 4'd1;
        cnt2_d = cnt2_q;
        if (cnt1_q == 4'd6)
            cnt2_d = (cnt2_q == 4'd6) ? 4'd1 : cnt2_q + 4'd1;

        state_d = state_q;
        dice1_d = dice1_q;
        dice2_d = dice2_q;
        point_d = point_q;
        pa_d    = pa_q;
        win_d   = win_q;
        lose_d  = lose_q;

        if (roll_pulse) begin
            case (state_q)
                COMEOUT: begin
                    dice1_d = cnt1_q;
                    dice2_d = cnt2_q;
                    if (sum == 4'd7 || sum == 4'd11) begin
                        state_d = WIN;
                        win_d   = 1'b1;
                    end else if (sum == 4'd2 || sum == 4'd3 || sum == 4'd12) begin
                        state_d = LOSE;
                        lose_d  = 1'b1;
                    end else begin
                        state_d = POINT;
                        point_d = sum;
                        pa_d    = 1'b1;
                    end
                end
                POINT: begin
                    dice1_d = cnt1_q;
                    dice2_d = cnt2_q;
                    if (sum == point_q) begin
                        state_d = WIN;
                        win_d   = 1'b1;
                    end else if (sum == 4'd7) begin
                        state_d = LOSE;
                        lose_d  = 1'b1;
                    end
                end
                // point stays visible through the result; cleared only here
                WIN, LOSE: begin
                    state_d = COMEOUT;
                    dice1_d = 4'd0;
                    dice2_d = 4'd0;
                    point_d = 4'd0;
                    pa_d    = 1'b0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
                default: state_d = COMEOUT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COMEOUT;
            cnt1_q  <= DIE1_INIT;
            cnt2_q  <= DIE2_INIT;
            dice1_q <= 4'd0;
            dice2_q <= 4'd0;
            point_q <= 4'd0;
            pa_q    <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            // a button held through reset must be released before it counts
            roll_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            dice1_q <= dice1_d;
            dice2_q <= dice2_d;
            point_q <= point_d;
            pa_q    <= pa_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            roll_q  <= roll_d;
        end
    end

    assign bus.dice1        = dice1_q;
    assign bus.dice2        = dice2_q;
    assign bus.point        = point_q;
    assign bus.point_active = pa_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
endmodule

// File: tb/tb_craps_game_ctrl.sv
// Directed bench for craps_game_ctrl: rolls are timed against a counter model
// so each capture sees chosen dice; expected outputs are hand-derived.
module tb_craps_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    int   m1, m2;

    craps_game_ctrl_if bus_if ();

    craps_game_ctrl #(.DIE1_INIT(4'd1), .DIE2_INIT(4'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // dice counter reference: values visible between edges feed the next capture
    always @(posedge clk) begin
        if (rst) begin
            m1 <= 1;
            m2 <= 1;
        end else begin
            m1 <= (m1 == 6) ? 1 : m1 + 1;
            if (m1 == 6) m2 <= (m2 == 6) ? 1 : m2 + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int d1, input int d2, input int pt,
                           input int pa, input int w, input int l);
        chk({tag, ".dice1"}, int'(bus_if.dice1), d1);
        chk({tag, ".dice2"}, int'(bus_if.dice2), d2);
        chk({tag, ".point"}, int'(bus_if.point), pt);
        chk({tag, ".pa"},    int'(bus_if.point_active), pa);
        chk({tag, ".win"},   int'(bus_if.win), w);
        chk({tag, ".lose"},  int'(bus_if.lose), l);
    endtask

    // Pulse roll so the capturing edge sees dice (a,b); a==0 means any dice.
    // Returns at edge+1 with roll low again.
    task automatic roll_at(input int a, input int b);
        bit hit = 0;
        bus_if.roll = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (a == 0 || (m1 == a && m2 == b)) hit = 1;
        end
        if (!hit) begin
            chk("roll_timeout", 0, 1);
        end else begin
            bus_if.roll = 1'b1;
            @(posedge clk);
            #1 bus_if.roll = 1'b0;
        end
    endtask

    initial begin
        int bad;
        bit [35:0] seen;
        bus_if.roll = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1 chk_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset.cnt1", int'(dut.cnt1_q), 1);
        chk("reset.cnt2", int'(dut.cnt2_q), 1);
        rst = 1'b0;

        // counter sequence: 36 clocks give every (cnt1,cnt2) pair in order
        bad = 0;
        seen = '0;
        for (int k = 0; k < 36; k++) begin
            if (int'(dut.cnt1_q) != k % 6 + 1 || int'(dut.cnt2_q) != k / 6 + 1) bad++;
            if (dut.cnt1_q >= 1 && dut.cnt1_q <= 6 && dut.cnt2_q >= 1 && dut.cnt2_q <= 6)
                seen[(int'(dut.cnt2_q) - 1) * 6 + int'(dut.cnt1_q) - 1] = 1'b1;
            @(negedge clk);
        end
        chk("cnt_seq.bad", bad, 0);
        chk("cnt_seq.cover", int'(seen == {36{1'b1}}), 1);

        // come-out naturals and craps
        roll_at(3, 4); chk_out("co34", 3, 4, 0, 0, 1, 0);
        roll_at(0, 0); chk_out("clr1", 0, 0, 0, 0, 0, 0);
        roll_at(1, 1); chk_out("co11", 1, 1, 0, 0, 0, 1);
        roll_at(0, 0); chk_out("clr2", 0, 0, 0, 0, 0, 0);
        roll_at(6, 6); chk_out("co66", 6, 6, 0, 0, 0, 1);
        roll_at(0, 0); chk_out("clr3", 0, 0, 0, 0, 0, 0);
        roll_at(5, 6); chk_out("co56", 5, 6, 0, 0, 1, 0);
        roll_at(0, 0);

        // point 6: miss, hold, then make it
        roll_at(2, 4); chk_out("pt6", 2, 4, 6, 1, 0, 0);
        roll_at(1, 2); chk_out("pt6.miss", 1, 2, 6, 1, 0, 0);
        repeat (5) @(posedge clk);
        #1 chk_out("pt6.hold", 1, 2, 6, 1, 0, 0);
        roll_at(3, 3); chk_out("pt6.win", 3, 3, 6, 1, 1, 0);
        roll_at(0, 0); chk_out("clr4", 0, 0, 0, 0, 0, 0);

        // point 8 sevens out, then a fresh come-out
        roll_at(4, 4); chk_out("pt8", 4, 4, 8, 1, 0, 0);
        roll_at(2, 5); chk_out("pt8.lose", 2, 5, 8, 1, 0, 1);
        roll_at(0, 0); chk_out("clr5", 0, 0, 0, 0, 0, 0);
        roll_at(3, 4); chk_out("co34b", 3, 4, 0, 0, 1, 0);
        roll_at(0, 0);

        // held roll: one capture only across 20 clocks
        bus_if.roll = 1'b0;
        @(posedge clk);
        begin
            bit hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (m1 == 2 && m2 == 4) hit = 1;
            end
            chk("held.sync", int'(hit), 1);
        end
        bus_if.roll = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk_out("held", 2, 4, 6, 1, 0, 0);
        bus_if.roll = 1'b0;

        // reset in POINT on the same edge as a roll pulse
        @(posedge clk);
        @(negedge clk);
        bus_if.roll = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_out("rst_pt", 0, 0, 0, 0, 0, 0);
        chk("rst_pt.cnt1", int'(dut.cnt1_q), 1);
        @(negedge clk);
        rst = 1'b0;
        // roll still held across reset release: must not capture
        repeat (10) @(posedge clk);
        #1 chk_out("rst_held", 0, 0, 0, 0, 0, 0);
        roll_at(3, 4); chk_out("post_rst", 3, 4, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/craps_game_ctrl.md
CRAPS_GAME_CTRL -- requirements
Module: craps_game_ctrl

Interface
REQ-001 Parameter DIE1_INIT, default 4'd1, die-1 counter value after reset; legal range 1..6.
REQ-002 Parameter DIE2_INIT, default 4'd1, die-2 counter value after reset; legal range 1..6.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port roll, input, 1 bit: roll request, level from an already synchronised and debounced button.
REQ-006 The block SHALL have port dice1, output, 4 bits: die 1 value (0 = blank, else 1..6), feeds the seven-segment display.
REQ-007 The block SHALL have port dice2, output, 4 bits: die 2 value (0 = blank, else 1..6), feeds the seven-segment display.
REQ-008 The block SHALL have port point, output, 4 bits: established point (0 when none; else 4,5,6,8,9,10).
REQ-009 The block SHALL have port point_active, output, 1 bit: high while a point is established.
REQ-010 The block SHALL have port win, output, 1 bit: game won, held until the next game starts.
REQ-011 The block SHALL have port lose, output, 1 bit: game lost, held until the next game starts.

Function
REQ-012 Dice generator: cnt1 SHALL step 1..6 every clock and wrap 6->1; cnt2 SHALL advance 1..6 (wrap 6->1) only on clocks where cnt1 wraps; both run in every state.
REQ-013 Roll edge: roll_q SHALL register roll; roll_pulse = roll & ~roll_q; only roll_pulse is acted on, and a held roll SHALL produce exactly one pulse.
REQ-014 Sum SHALL be cnt1+cnt2 computed in 4 bits (range 2..12, no overflow), using the counter values present before the capturing edge.
REQ-015 FSM states SHALL be COMEOUT, POINT, WIN, LOSE.
REQ-016 In COMEOUT on roll_pulse: dice1<=cnt1, dice2<=cnt2; sum 7 or 11 -> WIN, win<=1; sum 2, 3 or 12 -> LOSE, lose<=1; otherwise point<=sum, point_active<=1 -> POINT.
REQ-017 In POINT on roll_pulse: dice1/dice2 SHALL load; sum==point -> WIN, win<=1; else sum==7 -> LOSE, lose<=1; else stay in POINT with point unchanged.
REQ-018 On leaving POINT, point and point_active SHALL hold their values, so the display keeps showing the point through WIN/LOSE.
REQ-019 In WIN or LOSE on roll_pulse: -> COMEOUT; dice1, dice2, point SHALL clear to 0; point_active, win, lose SHALL clear to 0; no dice are captured on this pulse.
REQ-020 Latency: outputs SHALL reflect a roll on the same rising edge that samples roll_pulse high, which is one clock after roll rises.
REQ-021 Without roll_pulse, all outputs SHALL hold.
REQ-022 win and lose SHALL never both be high.
REQ-023 point_active SHALL be high if and only if point != 0.

Reset
REQ-024 While rst=1 at a clock edge: state=COMEOUT; dice1=dice2=point=0; point_active=win=lose=0; cnt1=DIE1_INIT; cnt2=DIE2_INIT.
REQ-025 roll_q SHALL reset to 1, so a roll held through reset release produces no pulse until it is released and pressed again.
REQ-026 rst SHALL take priority over roll_pulse at the same edge, including a reset asserted mid-game in POINT, WIN or LOSE.

Verification
REQ-027 Reset, then roll pulse sampled when cnt1=3, cnt2=4 -> next edge dice1=3, dice2=4, win=1, state WIN, point_active=0.
REQ-028 Come-out with cnt1=1, cnt2=1 -> dice 1/1, lose=1; come-out with 6/6 -> lose=1; come-out with 5/6 -> win=1.
REQ-029 Come-out with 2/4 -> point=6, point_active=1; next roll 1/2 -> stay in POINT, point=6; next roll 3/3 -> win=1, point still 6.
REQ-030 Point 8 established (4/4), then roll 2/5 -> lose=1, point=8, point_active=1; next roll pulse -> all outputs 0, state COMEOUT.
REQ-031 roll held high for 20 clocks -> exactly one capture; roll held across rst deassertion -> no capture until it drops and rises again.
REQ-032 rst asserted in POINT on the same edge as roll_pulse -> all outputs 0, cnt1=DIE1_INIT, no win or lose; counter sequence checked over 36 clocks covers all 36 (cnt1,cnt2) pairs.
